magic_cube_state_collect: RTL and testbench

- Sits directly downstream of the per-side facelet assembler.
- Accepts six 27-bit side words (9 facelets × 3-bit colour code), one per assembler done pulse, and assembles them into a 162-bit whole-cube state.
- Once all six sides are present, scans the 54 facelets, builds a per-colour histogram and validates the cube (every colour exactly 9 times, no illegal code).
- Presents the result with a one-cycle done pulse to the solver/display stage.

---
 rtl/magic_cube_state_collect.sv | 182 ++++++++++++++++++
 tb/tb_magic_cube_state_collect.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/magic_cube_state_collect.sv
// Collects six 27-bit cube sides into a 162-bit cube state, then scans all 54
// facelets into a per-colour histogram and flags whether the cube is legal.
module magic_cube_state_collect #(
    localparam int unsigned NUM_SIDES    = 6,
    localparam int unsigned FACELETS     = 9,
    localparam int unsigned COLOR_W      = 3,
    localparam int unsigned EXPECT_COUNT = 9,
    localparam int unsigned SIDE_W       = FACELETS * COLOR_W,
    localparam int unsigned STATE_W      = NUM_SIDES * SIDE_W,
    localparam int unsigned NUM_FACES    = NUM_SIDES * FACELETS,
    localparam int unsigned IDX_W        = $clog2(NUM_FACES),
    localparam int unsigned CNT_W        = $clog2(NUM_FACES + 1),
    localparam int unsigned OFS_W        = $clog2(STATE_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 abort,
    input  logic                 side_valid,
    input  logic [2:0]           side_index,
    input  logic [SIDE_W-1:0]    oneside_din,
    output logic [STATE_W-1:0]   cube_state,
    output logic [NUM_SIDES-1:0] side_mask,
    output logic                 busy,
    output logic                 cube_valid,
    output logic                 color_error,
    output logic                 index_error,
    output logic                 done
);

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_SCAN, S_EVAL, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic [STATE_W-1:0]     r_cube_state;
    logic [NUM_SIDES-1:0]   r_side_mask, w_mask_next, w_side_onehot;
    logic [CNT_W-1:0]       r_hist [NUM_SIDES];
    logic [IDX_W-1:0]       r_scan_idx;
    logic                   r_bad, r_busy, r_cube_valid, r_color_error, r_index_error, r_done;
    logic                   w_start, w_accept, w_idx_err, w_scan_step, w_scan_start, w_eval, w_abort_busy;
    logic                   w_side_ok, w_last_idx, w_hist_ok;
    logic [OFS_W-1:0]       w_bit_ofs;
    logic [COLOR_W-1:0]     w_face;

    assign w_side_onehot = NUM_SIDES'(1) << side_index;
    assign w_side_ok     = side_valid && (side_index < 3'(NUM_SIDES));
    assign w_mask_next   = r_side_mask | (w_side_ok ? w_side_onehot : '0);
    assign w_last_idx    = (r_scan_idx == IDX_W'(NUM_FACES - 1));
    // Sides are 9 facelets of 3 bits, so facelet idx sits at bit 3*idx.
    assign w_bit_ofs     = OFS_W'(r_scan_idx) * OFS_W'(COLOR_W);
    assign w_face        = r_cube_state[w_bit_ofs +: COLOR_W];

    always_comb begin
        w_hist_ok = 1'b1;
        for (int c = 0; c < NUM_SIDES; c++) begin
            if (r_hist[c] != CNT_W'(EXPECT_COUNT)) w_hist_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_idx_err    = 1'b0;
        w_scan_step  = 1'b0;
        w_scan_start = 1'b0;
        w_eval       = 1'b0;
        w_abort_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_start = 1'b1;
                    w_next  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (side_valid) begin
                    w_accept  = w_side_ok;
                    w_idx_err = !w_side_ok;
                end
                if (&w_mask_next) begin
                    w_scan_start = 1'b1;
                    w_next       = S_SCAN;
                end
            end
            S_SCAN: begin
                w_scan_step = 1'b1;
                if (w_last_idx) w_next = S_EVAL;
            end
            S_EVAL: begin
                w_eval = 1'b1;
                w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Abort wins over every other request in the same cycle.
        if (abort) begin
            w_next       = S_IDLE;
            w_start      = 1'b0;
            w_accept     = 1'b0;
            w_idx_err    = 1'b0;
            w_scan_step  = 1'b0;
            w_scan_start = 1'b0;
            w_eval       = 1'b0;
            w_abort_busy = (r_state != S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cube_state  <= '1;
            r_side_mask   <= '0;
            r_cube_valid  <= 1'b0;
            r_color_error <= 1'b0;
            r_index_error <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (w_start) begin
                r_cube_state  <= '1;
                r_side_mask   <= '0;
                r_cube_valid  <= 1'b0;
                r_color_error <= 1'b0;
                r_index_error <= 1'b0;
            end
            if (w_accept) begin
                for (int s = 0; s < NUM_SIDES; s++) begin
                    if (side_index == 3'(s)) r_cube_state[s*SIDE_W +: SIDE_W] <= oneside_din;
                end
                r_side_mask <= w_mask_next;
            end
            if (w_idx_err)    r_index_error <= 1'b1;
            if (w_abort_busy) r_cube_valid  <= 1'b0;
            if (w_eval) begin
                r_cube_valid  <= !r_bad && w_hist_ok && !r_index_error;
                r_color_error <= !(!r_bad && w_hist_ok && !r_index_error);
            end
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
        end
    end

    // Facelet scan: one facelet per cycle into saturating colour counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_idx <= '0;
            r_bad      <= 1'b0;
            for (int c = 0; c < NUM_SIDES; c++) r_hist[c] <= '0;
        end else begin
            if (w_start) begin
                r_bad <= 1'b0;
                for (int c = 0; c < NUM_SIDES; c++) r_hist[c] <= '0;
            end
            if (w_start || w_scan_start) r_scan_idx <= '0;
            if (w_scan_step) begin
                if (w_face < COLOR_W'(NUM_SIDES)) begin
                    for (int c = 0; c < NUM_SIDES; c++) begin
                        if (w_face == COLOR_W'(c) && r_hist[c] != CNT_W'(NUM_FACES))
                            r_hist[c] <= r_hist[c] + CNT_W'(1);
                    end
                end else begin
                    r_bad <= 1'b1;
                end
                if (!w_last_idx) r_scan_idx <= r_scan_idx + IDX_W'(1);
            end
        end
    end

    assign cube_state  = r_cube_state;
    assign side_mask   = r_side_mask;
    assign busy        = r_busy;
    assign cube_valid  = r_cube_valid;
    assign color_error = r_color_error;
    assign index_error = r_index_error;
    assign done        = r_done;

endmodule

// File: tb/tb_magic_cube_state_collect.sv
// Scenario bench for magic_cube_state_collect: expected run results are queued
// when a collection starts and popped when the done pulse arrives.
module tb_magic_cube_state_collect;

    logic         clk = 1'b0;
    logic         rst, enable, abort, side_valid;
    logic [2:0]   side_index;
    logic [26:0]  oneside_din;
    logic [161:0] cube_state;
    logic [5:0]   side_mask;
    logic         busy, cube_valid, color_error, index_error, done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         cv;
        logic         ce;
        logic         ie;
        logic [161:0] cs;
        int           lat;
    } exp_t;

    exp_t sb[$];

    magic_cube_state_collect dut (
        .clk(clk), .rst(rst), .enable(enable), .abort(abort),
        .side_valid(side_valid), .side_index(side_index), .oneside_din(oneside_din),
        .cube_state(cube_state), .side_mask(side_mask), .busy(busy),
        .cube_valid(cube_valid), .color_error(color_error),
        .index_error(index_error), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] solved_side(input int s);
        logic [2:0] c;
        c = 3'(s);
        return {9{c}};
    endfunction

    function automatic logic [161:0] solved_cube();
        logic [161:0] v;
        for (int s = 0; s < 6; s++) v[27*s +: 27] = solved_side(s);
        return v;
    endfunction

    task automatic send_side(input logic [2:0] idx, input logic [26:0] data);
        @(negedge clk);
        side_valid  = 1'b1;
        side_index  = idx;
        oneside_din = data;
        @(negedge clk);
        side_valid  = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    // Called right after the accepting edge of the last side; lat counts that edge.
    task automatic wait_done(output int lat, output bit got);
        lat = 1;
        got = 1'b0;
        while (lat < 200) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cube_state !== '1 || side_mask !== 6'h00) begin
            failures++;
            $display("FAIL reset_state: cube=%h mask=%h want all-ones/00", cube_state, side_mask);
        end
        checks++;
        if ({busy, cube_valid, color_error, index_error, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00000", {busy, cube_valid, color_error, index_error, done});
        end
        rst = 1'b0;
        send_side(3'd0, 27'h0);
        checks++;
        if (side_mask !== 6'h00 || cube_state !== '1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore: mask=%h busy=%b want 00/0", side_mask, busy);
        end
    endtask

    task automatic test_solved();
        exp_t e;
        int   lat;
        bit   got;
        sb.push_back('{cv: 1'b1, ce: 1'b0, ie: 1'b0, cs: solved_cube(), lat: 56});
        start_run();
        for (int s = 0; s < 6; s++) send_side(3'(s), solved_side(s));
        wait_done(lat, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            failures++;
            $display("FAIL solved_latency: got %0d (seen=%0b) want %0d", lat, got, e.lat);
        end
        checks++;
        if ({cube_valid, color_error, index_error} !== {e.cv, e.ce, e.ie}) begin
            failures++;
            $display("FAIL solved_flags: got %b want %b", {cube_valid, color_error, index_error}, {e.cv, e.ce, e.ie});
        end
        checks++;
        if (cube_state !== e.cs) begin
            failures++;
            $display("FAIL solved_state: got %h want %h", cube_state, e.cs);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cube_valid !== 1'b1) begin
            failures++;
            $display("FAIL solved_pulse: done=%b busy=%b valid=%b want 0/0/1", done, busy, cube_valid);
        end
    endtask

    task automatic test_shuffled();
        logic [2:0] order [6] = '{3'd5, 3'd2, 3'd0, 3'd4, 3'd1, 3'd3};
        logic [5:0] masks [6] = '{6'h20, 6'h24, 6'h25, 6'h35, 6'h37, 6'h3F};
        exp_t e;
        int   lat;
        bit   got;
        sb.push_back('{cv: 1'b1, ce: 1'b0, ie: 1'b0, cs: solved_cube(), lat: 56});
        start_run();
        for (int i = 0; i < 6; i++) begin
            send_side(order[i], solved_side(int'(order[i])));
            checks++;
            if (side_mask !== masks[i]) begin
                failures++;
                $display("FAIL shuffled_mask%0d: got %h want %h", i, side_mask, masks[i]);
            end
            if (i < 5) repeat ($urandom_range(3, 10)) @(negedge clk);
        end
        wait_done(lat, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat || {cube_valid, color_error, index_error} !== {e.cv, e.ce, e.ie}) begin
            failures++;
            $display("FAIL shuffled_result: lat=%0d flags=%b want %0d/%b", lat, {cube_valid, color_error, index_error}, e.lat, {e.cv, e.ce, e.ie});
        end
        checks++;
        if (cube_state !== e.cs) begin
            failures++;
            $display("FAIL shuffled_state: got %h want %h", cube_state, e.cs);
        end
    endtask

    task automatic test_duplicate();
        exp_t e;
        int   lat;
        bit   got;
        sb.push_back('{cv: 1'b1, ce: 1'b0, ie: 1'b0, cs: solved_cube(), lat: 56});
        start_run();
        send_side(3'd0, solved_side(1));
        send_side(3'd0, solved_side(0));
        checks++;
        if (side_mask !== 6'h01 || busy !== 1'b1 || cube_state[26:0] !== 27'h0) begin
            failures++;
            $display("FAIL dup_overwrite: mask=%h busy=%b side0=%h want 01/1/0", side_mask, busy, cube_state[26:0]);
        end
        for (int s = 1; s < 6; s++) send_side(3'(s), solved_side(s));
        wait_done(lat, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat || {cube_valid, color_error, index_error} !== {e.cv, e.ce, e.ie}) begin
            failures++;
            $display("FAIL dup_result: lat=%0d flags=%b want %0d/%b", lat, {cube_valid, color_error, index_error}, e.lat, {e.cv, e.ce, e.ie});
        end
    endtask

    task automatic test_bad_color();
        logic [26:0]  s3, s2;
        logic [161:0] cs;
        exp_t e;
        int   lat;
        bit   got;
        for (int run = 0; run < 2; run++) begin
            s3 = solved_side(3);
            s2 = solved_side(2);
            if (run == 0) s3[14:12] = 3'b111;
            else          s2[2:0]   = 3'b000;
            cs = solved_cube();
            cs[81 +: 27] = s3;
            cs[54 +: 27] = s2;
            sb.push_back('{cv: 1'b0, ce: 1'b1, ie: 1'b0, cs: cs, lat: 56});
            start_run();
            for (int s = 0; s < 6; s++)
                send_side(3'(s), (s == 3) ? s3 : ((s == 2) ? s2 : solved_side(s)));
            wait_done(lat, got);
            e = sb.pop_front();
            checks++;
            if (!got || lat != e.lat || {cube_valid, color_error, index_error} !== {e.cv, e.ce, e.ie}) begin
                failures++;
                $display("FAIL bad_color%0d: lat=%0d flags=%b want %0d/%b", run, lat, {cube_valid, color_error, index_error}, e.lat, {e.cv, e.ce, e.ie});
            end
            checks++;
            if (cube_state !== e.cs) begin
                failures++;
                $display("FAIL bad_color%0d_state: got %h want %h", run, cube_state, e.cs);
            end
        end
    endtask

    task automatic test_index_error();
        exp_t e;
        int   lat;
        bit   got;
        sb.push_back('{cv: 1'b0, ce: 1'b1, ie: 1'b1, cs: solved_cube(), lat: 56});
        start_run();
        send_side(3'd0, solved_side(0));
        send_side(3'd6, 27'h1234567);
        checks++;
        if (index_error !== 1'b1 || side_mask !== 6'h01) begin
            failures++;
            $display("FAIL idx_sticky: ie=%b mask=%h want 1/01", index_error, side_mask);
        end
        for (int s = 1; s < 6; s++) send_side(3'(s), solved_side(s));
        wait_done(lat, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat != e.lat || {cube_valid, color_error, index_error} !== {e.cv, e.ce, e.ie}) begin
            failures++;
            $display("FAIL idx_result: lat=%0d flags=%b want %0d/%b", lat, {cube_valid, color_error, index_error}, e.lat, {e.cv, e.ce, e.ie});
        end
        checks++;
        if (cube_state !== e.cs) begin
            failures++;
            $display("FAIL idx_state: got %h want %h", cube_state, e.cs);
        end
    endtask

    task automatic test_abort();
        int seen;
        start_run();
        for (int s = 0; s < 3; s++) send_side(3'(s), solved_side(s));
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cube_valid !== 1'b0 || side_mask !== 6'h07) begin
            failures++;
            $display("FAIL abort_state: busy=%b done=%b valid=%b mask=%h want 0/0/0/07", busy, done, cube_valid, side_mask);
        end
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d pulses want 0", seen);
        end
        test_solved();
    endtask

    task automatic test_reset_midscan();
        int seen;
        start_run();
        for (int s = 0; s < 6; s++) send_side(3'(s), solved_side(s));
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || side_mask !== 6'h00 || cube_state !== '1) begin
            failures++;
            $display("FAIL rst_scan_async: busy=%b done=%b mask=%h want 0/0/00", busy, done, side_mask);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_scan_busy: got %b want 0", busy);
        end
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_scan_no_done: got %0d pulses want 0", seen);
        end
        test_solved();
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        abort       = 1'b0;
        side_valid  = 1'b0;
        side_index  = 3'd0;
        oneside_din = 27'h0;
        test_reset();
        test_solved();
        test_shuffled();
        test_duplicate();
        test_bad_color();
        test_index_error();
        test_abort();
        test_reset_midscan();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
